mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the IF stage fetch port and the MEM stage load/store port.
- Serializes the two requests and issues one memory transaction at a time.
- Drives the IF and MEM stall inputs until each requester's transaction completes.
- Sits between the pipeline stages and the memory wrapper. It also discards fetch results when a branch flush arrives.

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_timeout.sv | 28 ++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Imported by the arbiter top and its timeout counter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam int         TO_W    = 8;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the IF/MEM stages, the arbiter and the memory wrapper.
// slave = arbiter side, master = pipeline and memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_flush;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;

    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic          mem_stall;

    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_ready;
    logic          timeout_err;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  ram_rdata, ram_ready,
        output if_rdata, if_valid, if_stall,
        output mem_rdata, mem_valid, mem_stall,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output timeout_err
    );

    modport master (
        output if_req, if_addr, if_flush,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output ram_rdata, ram_ready,
        input  if_rdata, if_valid, if_stall,
        input  mem_rdata, mem_valid, mem_stall,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  timeout_err
    );

endinterface

// File: rtl/mem_port_timeout.sv
// Busy-cycle counter; flags expiry on the last allowed wait cycle.
// Cleared whenever the port is idle or the memory answers.
module mem_port_timeout
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TO_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + TO_W'(1);
    end

    assign expired = en & (count == TO_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes IF fetches and MEM loads/stores onto one single-port memory.
// MEM wins in IDLE except for the one grant right after a MEM completion.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
);

    state_t        state, state_d;
    owner_t        owner;
    logic          busy, done, expired, if_ok;
    logic          grant_if, grant_mem;
    logic          if_prio, drop_fetch;
    logic [AW-1:0] grant_addr;
    logic [DW-1:0] resp;

    logic [3:0]    ram_we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic [DW-1:0] if_rdata_q, mem_rdata_q;
    logic          if_valid_q, mem_valid_q, err_q;

    assign busy       = (state != ST_IDLE);
    assign owner      = (state == ST_MEM_BUSY) ? OWN_MEM : OWN_IF;
    assign done       = busy & (bus.ram_ready | expired);
    assign if_ok      = bus.if_req & ~bus.if_flush;
    assign grant_addr = grant_mem ? bus.mem_addr : bus.if_addr;
    assign resp       = bus.ram_ready ? bus.ram_rdata : '0;

    mem_port_timeout #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (~busy | bus.ram_ready),
        .en     (busy & ~bus.ram_ready),
        .expired(expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d   = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (if_prio && if_ok)
                    grant_if = 1'b1;
                else if (bus.mem_req)
                    grant_mem = 1'b1;
                else if (if_ok)
                    grant_if = 1'b1;
                if (grant_mem)
                    state_d = ST_MEM_BUSY;
                else if (grant_if)
                    state_d = ST_IF_BUSY;
            end
            ST_IF_BUSY, ST_MEM_BUSY: begin
                if (done)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_we_q    <= BE_NONE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            err_q       <= 1'b0;
            drop_fetch  <= 1'b0;
            if_prio     <= 1'b0;
        end else begin
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            if (grant_if || grant_mem) begin
                ram_addr_q <= grant_addr;
                ram_we_q   <= (grant_mem && bus.mem_we) ? bus.mem_be : BE_NONE;
                if_prio    <= 1'b0;
            end
            if (grant_mem)
                ram_wdata_q <= bus.mem_wdata;
            // a flush on the completing cycle also discards the fetch
            if (busy && owner == OWN_IF) begin
                drop_fetch <= (drop_fetch | bus.if_flush) & ~done;
                if (done && !(drop_fetch || bus.if_flush)) begin
                    if_valid_q <= 1'b1;
                    if_rdata_q <= resp;
                end
            end
            if (done && owner == OWN_MEM) begin
                mem_valid_q <= 1'b1;
                mem_rdata_q <= resp;
                if_prio     <= 1'b1;
            end
            if (expired)
                err_q <= 1'b1;
        end
    end

    assign bus.ram_en      = busy;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.if_stall    = bus.if_req & ~if_valid_q;
    assign bus.mem_rdata   = mem_rdata_q;
    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_stall   = bus.mem_req & ~mem_valid_q;
    assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed test-plan scenarios plus random traffic against a
// transaction-level model of the shared memory port.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int TMO   = 4;
    localparam int NONE  = 0;
    localparam int FETCH = 1;
    localparam int DATA  = 2;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model of the port: who owns it, how long it has waited
    int          m_own, m_wait, m_lat;
    bit          m_drop, m_fair, m_err, m_ifv, m_memv;
    logic [31:0] m_addr, m_wdata, m_ifr, m_memr;
    logic [3:0]  m_we;
    int          lat_cfg;
    bit          rand_rd;
    logic [31:0] rd_val;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = NONE; m_wait = 0; m_lat = 0;
        m_drop = 0; m_fair = 0; m_err = 0; m_ifv = 0; m_memv = 0;
        m_addr = '0; m_wdata = '0; m_ifr = '0; m_memr = '0; m_we = '0;
    endtask

    task automatic model_step();
        logic [31:0] data;
        bit ifok;
        int g;
        m_ifv  = 0;
        m_memv = 0;
        if (m_own == NONE) begin
            ifok = bus.if_req && !bus.if_flush;
            g = NONE;
            if (m_fair && ifok) g = FETCH;
            else if (bus.mem_req) g = DATA;
            else if (ifok) g = FETCH;
            if (g != NONE) begin
                m_fair = 0;
                m_wait = 0;
                m_own = g;
                m_lat = (lat_cfg < 0) ? int'($urandom_range(0, 5)) : lat_cfg;
                if (g == DATA) begin
                    m_addr  = bus.mem_addr;
                    m_wdata = bus.mem_wdata;
                    m_we    = bus.mem_we ? bus.mem_be : 4'h0;
                end else begin
                    m_addr = bus.if_addr;
                    m_we   = 4'h0;
                end
            end
        end else begin
            if (m_own == FETCH && bus.if_flush) m_drop = 1;
            if (bus.ram_ready || m_wait == TMO - 1) begin
                data = bus.ram_ready ? bus.ram_rdata : 32'h0;
                if (!bus.ram_ready) m_err = 1;
                if (m_own == FETCH) begin
                    if (!m_drop) begin
                        m_ifv = 1;
                        m_ifr = data;
                    end
                    m_drop = 0;
                end else begin
                    m_memv = 1;
                    m_memr = data;
                    m_fair = 1;
                end
                m_own = NONE;
            end else begin
                m_wait++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("ram_en", bus.ram_en, m_own != NONE);
        if (m_own != NONE) begin
            chk("ram_addr", bus.ram_addr, m_addr);
            chk("ram_we", bus.ram_we, m_we);
            if (m_own == DATA) chk("ram_wdata", bus.ram_wdata, m_wdata);
        end
        chk("if_valid", bus.if_valid, m_ifv);
        chk("mem_valid", bus.mem_valid, m_memv);
        chk("if_rdata", bus.if_rdata, m_ifr);
        chk("mem_rdata", bus.mem_rdata, m_memr);
        chk("timeout_err", bus.timeout_err, m_err);
        chk("if_stall", bus.if_stall, bus.if_req & ~m_ifv);
        chk("mem_stall", bus.mem_stall, bus.mem_req & ~m_memv);
    endtask

    // memory answers m_lat cycles into a transaction, then the edge
    task automatic tick();
        bus.ram_ready = (m_own != NONE) && (m_wait >= m_lat);
        bus.ram_rdata = rand_rd ? $urandom : rd_val;
        model_step();
        @(negedge clk);
        check_outputs();
        cyc++;
    endtask

    task automatic idle_inputs();
        bus.if_req = 0; bus.if_flush = 0; bus.if_addr = '0;
        bus.mem_req = 0; bus.mem_we = 0; bus.mem_be = '0;
        bus.mem_addr = '0; bus.mem_wdata = '0;
        bus.ram_ready = 0; bus.ram_rdata = '0;
    endtask

    task automatic drain();
        bus.if_req = 0;
        bus.mem_req = 0;
        bus.if_flush = 0;
        for (int i = 0; i < 12 && m_own != NONE; i++) tick();
        chk("drain_idle", m_own, NONE);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt, mem_first, if_first, mvc, ng;
        bit prev_en;
        int grants[5];
        int exp_g[5];
        exp_g = '{DATA, FETCH, DATA, FETCH, DATA};
        lat_cfg = 0;
        rand_rd = 0;
        rd_val = '0;
        rst = 0;
        idle_inputs();
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1;

        // IF only, minimum latency
        bus.if_req = 1;
        bus.if_addr = 32'h40;
        rd_val = 32'h2408_0005;
        tick();
        chk("ifonly_addr", bus.ram_addr, 32'h40);
        chk("ifonly_stall", bus.if_stall, 1);
        tick();
        chk("ifonly_valid", bus.if_valid, 1);
        chk("ifonly_data", bus.if_rdata, 32'h2408_0005);
        drain();

        // contention: store vs fetch
        bus.if_req = 1;
        bus.if_addr = 32'h40;
        bus.mem_req = 1;
        bus.mem_we = 1;
        bus.mem_be = BE_WORD;
        bus.mem_addr = 32'h100;
        bus.mem_wdata = 32'hDEAD_BEEF;
        lat_cfg = 1;
        tick();
        chk("cont_we", bus.ram_we, 4'hF);
        chk("cont_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
        chk("cont_addr", bus.ram_addr, 32'h100);
        mem_first = -1;
        if_first = -1;
        for (int i = 0; i < 20 && (mem_first < 0 || if_first < 0); i++) begin
            tick();
            if (mem_first < 0 && !bus.mem_stall) mem_first = cyc;
            if (if_first < 0 && !bus.if_stall) if_first = cyc;
            if (bus.mem_valid) bus.mem_req = 0;
            if (bus.if_valid) bus.if_req = 0;
        end
        chk("cont_done", (mem_first >= 0) && (if_first >= 0), 1);
        chk("cont_order", mem_first < if_first, 1);
        drain();

        // fairness under back-to-back MEM traffic
        bus.if_req = 1;
        bus.if_addr = 32'h40;
        bus.mem_req = 1;
        bus.mem_we = 0;
        bus.mem_addr = 32'h300;
        lat_cfg = 1;
        mvc = 0;
        ng = 0;
        prev_en = 0;
        for (int i = 0; i < 60 && ng < 5; i++) begin
            tick();
            if (bus.ram_en && !prev_en) begin
                grants[ng] = (bus.ram_addr == 32'h300) ? DATA : FETCH;
                ng++;
            end
            prev_en = bus.ram_en;
            if (bus.mem_valid) mvc++;
            if (mvc >= 3) bus.mem_req = 0;
        end
        chk("fair_count", ng, 5);
        for (int i = 0; i < 5; i++)
            if (i < ng) chk($sformatf("fair_grant%0d", i), grants[i], exp_g[i]);
        drain();

        // flush during a slow fetch
        bus.if_req = 1;
        bus.if_addr = 32'h80;
        lat_cfg = 3;
        rd_val = 32'h1111_1111;
        vcnt = 0;
        tick();
        bus.if_flush = 1;
        tick();
        bus.if_flush = 0;
        bus.if_addr = 32'h200;
        lat_cfg = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.if_valid) vcnt++;
        end
        chk("flush_novalid", vcnt, 0);
        chk("flush_keep", bus.if_rdata, 32'h2408_0005);
        rd_val = 32'h2222_2222;
        tick();
        chk("flush_next_addr", bus.ram_addr, 32'h200);
        tick();
        chk("flush_next_valid", bus.if_valid, 1);
        chk("flush_next_data", bus.if_rdata, 32'h2222_2222);
        drain();

        // timeout on a load
        bus.mem_req = 1;
        bus.mem_we = 0;
        bus.mem_addr = 32'h104;
        lat_cfg = 100;
        rd_val = 32'h5555_5555;
        tick();
        bus.mem_req = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("tmo_en_held", bus.ram_en, 1);
        tick();
        chk("tmo_en_drop", bus.ram_en, 0);
        chk("tmo_err", bus.timeout_err, 1);
        chk("tmo_valid", bus.mem_valid, 1);
        chk("tmo_rdata", bus.mem_rdata, 0);
        drain();

        // asynchronous reset in the middle of a store
        bus.mem_req = 1;
        bus.mem_we = 1;
        bus.mem_be = 4'h3;
        bus.mem_addr = 32'h108;
        bus.if_req = 1;
        bus.if_addr = 32'h44;
        lat_cfg = 100;
        tick();
        tick();
        #2;
        rst = 0;
        #1;
        chk("rst_en", bus.ram_en, 0);
        chk("rst_we", bus.ram_we, 0);
        chk("rst_err", bus.timeout_err, 0);
        chk("rst_mstall", bus.mem_stall, 1);
        chk("rst_istall", bus.if_stall, 1);
        model_reset();
        bus.mem_req = 0;
        lat_cfg = 0;
        rd_val = 32'h3333_3333;
        @(negedge clk);
        rst = 1;
        tick();
        tick();
        chk("rst_fetch", bus.if_rdata, 32'h3333_3333);
        drain();

        // random traffic
        lat_cfg = -1;
        rand_rd = 1;
        for (int i = 0; i < 1500; i++) begin
            bus.if_req = ($urandom % 10) < 7;
            bus.if_flush = ($urandom % 10) == 0;
            bus.if_addr = $urandom & 32'hFFFF_FFFC;
            bus.mem_req = ($urandom % 10) < 4;
            bus.mem_we = $urandom;
            bus.mem_be = $urandom;
            bus.mem_addr = $urandom;
            bus.mem_wdata = $urandom;
            tick();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
